// File: rtl/timer_pkg.sv
// Shared widths, state encoding and arithmetic helpers for countdown_timer.
// Consumers import with: import timer_pkg::*;
package timer_pkg;

    localparam int TIME_W = 12;
    localparam int STEP_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        RUN,
        EXPIRE
    } state_t;

    // Floor at zero rather than wrapping when the step exceeds the time left
    function automatic logic [TIME_W-1:0] sat_sub(
        input logic [TIME_W-1:0] t,
        input logic [STEP_W-1:0] s
    );
        logic [TIME_W-1:0] sx;
        sx = {{(TIME_W-STEP_W){1'b0}}, s};
        return (t > sx) ? (t - sx) : '0;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides Clk down to a one-cycle Tick every TICK_DIV enabled cycles.
// The partial count is held while En is low; Clr restarts the period.
module tick_prescaler #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic Clk,
    input  logic ResetN,
    input  logic En,
    input  logic Clr,
    output logic Tick
);

    localparam int CW = $clog2(TICK_DIV);
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt;

    assign Tick = En && !Clr && (cnt == LAST);

    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            cnt <= '0;
        end else if (Clr || Tick) begin
            cnt <= '0;
        end else if (En) begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/countdown_timer.sv
// Loadable seconds countdown with saturating per-tick step and Done pulse.
// Optional buzzer after expiry: define TIMER_BEEP_EN.
module countdown_timer
    import timer_pkg::*;
#(
    parameter int TICK_DIV     = 50_000_000,
    parameter int BEEP_SECONDS = 3
) (
    input  logic              Clk,
    input  logic              ResetN,
    input  logic              LoadEn,
    input  logic [TIME_W-1:0] LoadTime,
    input  logic              Cancel,
    input  logic              CounterEnable,
    input  logic [STEP_W-1:0] CounterInput,
    output logic [TIME_W-1:0] PresentTime,
    output logic              Done,
    output logic              Beep
);

    if (TICK_DIV < 2 || BEEP_SECONDS < 1) begin : g_bad_param
        $error("countdown_timer: TICK_DIV must be >= 2, BEEP_SECONDS >= 1");
    end

    state_t            state;
    logic              live;
    logic              pre_clr;
    logic              run_en;
    logic              pre_en;
    logic              tick;
    logic              expire_now;
    logic [TIME_W-1:0] next_time;

    assign live       = (PresentTime != '0);
    assign pre_clr    = Cancel || LoadEn;
    assign run_en     = live && CounterEnable && !pre_clr;
    assign next_time  = sat_sub(PresentTime, CounterInput);
    assign expire_now = run_en && tick && (next_time == '0);

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_pre (
        .Clk    (Clk),
        .ResetN (ResetN),
        .En     (pre_en),
        .Clr    (pre_clr),
        .Tick   (tick)
    );

    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            state       <= IDLE;
            PresentTime <= '0;
            Done        <= 1'b0;
        end else begin
            Done <= 1'b0;
            if (Cancel) begin
                state       <= IDLE;
                PresentTime <= '0;
            end else if (LoadEn) begin
                PresentTime <= LoadTime;
                state       <= (LoadTime == '0) ? IDLE : ARMED;
            end else begin
                unique case (state)
                    IDLE: begin
                        state <= IDLE;
                    end
                    EXPIRE: begin
                        state <= IDLE;
                    end
                    ARMED, RUN: begin
                        if (expire_now) begin
                            PresentTime <= '0;
                            Done        <= 1'b1;
                            state       <= EXPIRE;
                        end else if (run_en && tick) begin
                            PresentTime <= next_time;
                            state       <= RUN;
                        end else begin
                            state <= CounterEnable ? RUN : ARMED;
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

`ifdef TIMER_BEEP_EN
    localparam int BW = $clog2(BEEP_SECONDS + 1);

    logic [BW-1:0] beep_left;

    // Prescaler keeps running through the beep so it is timed in seconds
    assign pre_en = run_en || (Beep && !pre_clr);

    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            Beep      <= 1'b0;
            beep_left <= '0;
        end else if (pre_clr) begin
            Beep      <= 1'b0;
            beep_left <= '0;
        end else if (expire_now) begin
            Beep      <= 1'b1;
            beep_left <= BW'(BEEP_SECONDS);
        end else if (Beep && tick) begin
            if (beep_left == BW'(1)) begin
                Beep <= 1'b0;
            end
            beep_left <= beep_left - BW'(1);
        end
    end
`else
    assign pre_en = run_en;
    assign Beep   = 1'b0;
`endif

endmodule
